sprite_pixel_fetcher: RTL

Upstream stage of the pixel composer. On each start_fetch pulse it resolves the sprite colour covering the requested screen pixel (pixel_x, pixel_y).
- Scans an internal sprite attribute table in priority order (index 0 = highest).
- Reads the sprite pattern ROM for the first hit.
- Skips transparent texels.
- Returns colour plus a hit flag with a one-cycle fetch_done pulse, which the composer uses to leave its wait state.

---
 rtl/vpu_pkg.sv | 23 ++
 rtl/sprite_hit_test.sv | 31 +++
 rtl/sprite_pixel_fetcher.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vpu_pkg.sv
// Shared video-pipeline definitions: sprite attribute layout, screen size,
// colour format and sprite fetcher FSM encodings.
package vpu_pkg;
  localparam int X_LSB    = 0;
  localparam int X_W      = 10;
  localparam int Y_LSB    = 10;
  localparam int Y_W      = 9;
  localparam int TILE_LSB = 19;
  localparam int EN_BIT   = 25;
  localparam int ATTR_W   = 26;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int                 COLOR_W     = 9;
  localparam logic [COLOR_W-1:0] TRANSPARENT = 9'h1FF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/sprite_hit_test.sv
// Combinational test of one pixel against one square sprite; returns hit and
// the in-sprite texel offsets. Off-screen origins clip, never wrap.
module sprite_hit_test
  import vpu_pkg::*;
#(
  parameter int SIZE_LOG2 = 4
) (
  input  logic [X_W-1:0]       px,
  input  logic [Y_W-1:0]       py,
  input  logic [X_W-1:0]       sx,
  input  logic [Y_W-1:0]       sy,
  input  logic                 en,
  output logic                 hit,
  output logic [SIZE_LOG2-1:0] dx,
  output logic [SIZE_LOG2-1:0] dy
);
  localparam logic [X_W-1:0] SIDE_X = X_W'(1 << SIZE_LOG2);
  localparam logic [Y_W-1:0] SIDE_Y = Y_W'(1 << SIZE_LOG2);

  logic [X_W:0] dx_full;
  logic [Y_W:0] dy_full;

  // The extra MSB is the borrow: pixel left of / above the sprite origin.
  assign dx_full = {1'b0, px} - {1'b0, sx};
  assign dy_full = {1'b0, py} - {1'b0, sy};

  assign hit = en & ~dx_full[X_W] & ~dy_full[Y_W]
             & (dx_full[X_W-1:0] < SIDE_X) & (dy_full[Y_W-1:0] < SIDE_Y);
  assign dx  = dx_full[SIZE_LOG2-1:0];
  assign dy  = dy_full[SIZE_LOG2-1:0];
endmodule

// File: rtl/sprite_pixel_fetcher.sv
// Resolves the highest-priority opaque sprite texel under a requested pixel
// by scanning the attribute table and reading the synchronous pattern ROM.
module sprite_pixel_fetcher
  import vpu_pkg::*;
#(
  parameter int                 N_SPRITES   = 8,
  parameter int                 SIZE_LOG2   = 4,
  parameter int                 TILE_W      = 6,
  parameter int                 COLOR_W     = vpu_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT = vpu_pkg::TRANSPARENT,
  localparam int                IDX_W       = $clog2(N_SPRITES),
  localparam int                ROM_AW      = TILE_W + 2 * SIZE_LOG2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_fetch,
  input  logic [9:0]         pixel_x,
  input  logic [8:0]         pixel_y,
  input  logic               attr_we,
  input  logic [IDX_W-1:0]   attr_idx,
  input  logic [25:0]        attr_data,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               busy,
  output logic               fetch_done,
  output logic               sprite_hit,
  output logic [COLOR_W-1:0] sprite_pixel
);
  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [X_W-1:0]     px_q, px_d;
  logic [Y_W-1:0]     py_q, py_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic               hit_q, hit_d;
  logic [COLOR_W-1:0] pix_q, pix_d;
  logic [ATTR_W-1:0]  tbl_q [N_SPRITES];

  logic [ATTR_W-1:0]    cur_attr;
  logic                 cur_hit;
  logic [SIZE_LOG2-1:0] cur_dx, cur_dy;
  logic                 last_idx;

  // Table is read live, so writes landing before an entry is scanned are seen.
  assign cur_attr = tbl_q[idx_q];
  assign last_idx = (idx_q == IDX_W'(N_SPRITES - 1));

  sprite_hit_test #(.SIZE_LOG2(SIZE_LOG2)) u_hit_test (
    .px  (px_q),
    .py  (py_q),
    .sx  (cur_attr[X_LSB +: X_W]),
    .sy  (cur_attr[Y_LSB +: Y_W]),
    .en  (cur_attr[EN_BIT]),
    .hit (cur_hit),
    .dx  (cur_dx),
    .dy  (cur_dy)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    px_d       = px_q;
    py_d       = py_q;
    rom_addr_d = rom_addr_q;
    hit_d      = hit_q;
    pix_d      = pix_q;
    case (state_q)
      ST_IDLE: begin
        if (start_fetch) begin
          px_d    = pixel_x;
          py_d    = pixel_y;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cur_hit) begin
          rom_addr_d = {cur_attr[TILE_LSB +: TILE_W], cur_dy, cur_dx};
          state_d    = ST_READ;
        end else if (last_idx) begin
          hit_d   = 1'b0;
          pix_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_READ: state_d = ST_CHECK;
      ST_CHECK: begin
        if (rom_data != TRANSPARENT) begin
          hit_d   = 1'b1;
          pix_d   = rom_data;
          state_d = ST_DONE;
        end else if (last_idx) begin
          hit_d   = 1'b0;
          pix_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      px_q       <= px_d;
      py_q       <= py_d;
      rom_addr_q <= rom_addr_d;
      hit_q      <= hit_d;
      pix_q      <= pix_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SPRITES; i++) tbl_q[i] <= '0;
    end else if (attr_we) begin
      tbl_q[attr_idx] <= attr_data;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign busy         = (state_q != ST_IDLE);
  assign fetch_done   = (state_q == ST_DONE);
  assign sprite_hit   = hit_q;
  assign sprite_pixel = pix_q;
endmodule
